// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported instruction/data memory between the fetch stage
// (I side) and the memory stage (D side). A granted request is latched and
// holds the memory port for MEM_LAT cycles. A one-cycle ready then returns the
// read data. The block also drives the pipeline stalls and keeps a saturating
// count of cycles in which both stages are stalled at once.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   i_req/i_addr        fetch read request (held until i_ready)
//   i_rdata/i_ready     fetch data and one-cycle completion
//   d_req/d_we/d_addr/  data request, direction, address and store data
//   d_wdata
//   d_rdata/d_ready     load data and one-cycle completion
//   mem_en/mem_we/      memory port controls, driven from the latched request
//   mem_addr/mem_wdata
//   mem_rdata           memory read data, valid in the last access cycle
//   stall_f/stall_m     requester stalled (request pending, not completing)
//   conflict_cnt        saturating count of cycles with both stalls high
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_f,
    output logic              stall_m,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_e;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  conflict_q, conflict_d;

    logic done;
    logic take_i;
    logic take_d;

    // The last cycle of an access is the one in which the down-counter is 0.
    assign done = (state_q != IDLE) && (cnt_q == 4'd0);

    assign i_ready   = (state_q == GNT_I) && done;
    assign d_ready   = (state_q == GNT_D) && done;
    assign i_rdata   = i_ready ? mem_rdata : '0;
    assign d_rdata   = (d_ready && !we_q) ? mem_rdata : '0;
    assign mem_en    = (state_q != IDLE);
    assign mem_we    = (state_q == GNT_D) && we_q;
    assign mem_addr  = mem_en ? addr_q : '0;
    assign mem_wdata = (state_q == GNT_D) ? wdata_q : '0;

    // Stalls are gated by reset so that every output reads 0 while rst is low,
    // even though the requesters may still be holding their requests.
    assign stall_f = rst && i_req && !i_ready;
    assign stall_m = rst && d_req && !d_ready;

    assign conflict_cnt = conflict_q;

    // Next-state logic. At a completion the finishing side is never
    // re-granted, because its request is stale on that edge; the other side
    // is handed the port directly, which makes continuous requesters
    // alternate with no idle cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        take_i  = 1'b0;
        take_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_req) begin
                    take_d = 1'b1;
                end else if (i_req) begin
                    take_i = 1'b1;
                end
            end
            GNT_I: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (d_req) begin
                    take_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT_D: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (i_req) begin
                    take_i = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take_d) begin
            state_d = GNT_D;
            cnt_d   = LAT_M1;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            we_d    = d_we;
        end else if (take_i) begin
            state_d = GNT_I;
            cnt_d   = LAT_M1;
            addr_d  = i_addr;
            we_d    = 1'b0;
        end
    end

    // The conflict counter sticks at all-ones instead of wrapping.
    always_comb begin
        conflict_d = conflict_q;
        if (stall_f && stall_m && (conflict_q != '1)) begin
            conflict_d = conflict_q + CNT_W'(1);
        end
    end

    // State and latch registers. Reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            conflict_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            conflict_q <= conflict_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. The main instance (MEM_LAT=2,
// CNT_W=16) is compared against a behavioural model on every cycle, and
// hand-computed expectations are pinned at key cycles. A second instance
// (MEM_LAT=15, CNT_W=4) exercises saturation of the conflict counter.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall_f;
    logic          stall_m;
    logic [CW-1:0] conflict_cnt;

    logic          rstB;
    logic [DW-1:0] iRdataB;
    logic          iReadyB;
    logic [DW-1:0] dRdataB;
    logic          dReadyB;
    logic          memEnB;
    logic          memWeB;
    logic [AW-1:0] memAddrB;
    logic [DW-1:0] memWdataB;
    logic          stallFB;
    logic          stallMB;
    logic [3:0]    conflictB;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_f(stall_f), .stall_m(stall_m), .conflict_cnt(conflict_cnt)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(15), .CNT_W(4)) dutSat (
        .clk(clk), .rst(rstB),
        .i_req(1'b1), .i_addr(32'h0000_0004), .i_rdata(iRdataB), .i_ready(iReadyB),
        .d_req(1'b1), .d_we(1'b0), .d_addr(32'h0000_0008), .d_wdata(32'h0),
        .d_rdata(dRdataB), .d_ready(dReadyB),
        .mem_en(memEnB), .mem_we(memWeB), .mem_addr(memAddrB),
        .mem_wdata(memWdataB), .mem_rdata(32'h7777_7777),
        .stall_f(stallFB), .stall_m(stallMB), .conflict_cnt(conflictB)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model: who owns the port (0 none, 1 fetch, 2 data) and how
    // many cycles of the access have already elapsed.
    // ---------------------------------------------------------------------
    int          mOwner   = 0;
    int          mElapsed = 0;
    logic [31:0] mAddr    = '0;
    logic [31:0] mWdata   = '0;
    logic        mWe      = 1'b0;
    int          mConf    = 0;

    function automatic logic expIReady();
        return rst && (mOwner == 1) && (mElapsed == LAT - 1);
    endfunction

    function automatic logic expDReady();
        return rst && (mOwner == 2) && (mElapsed == LAT - 1);
    endfunction

    function automatic logic expStallF();
        return rst && i_req && !expIReady();
    endfunction

    function automatic logic expStallM();
        return rst && d_req && !expDReady();
    endfunction

    function automatic logic expMemEn();
        return rst && (mOwner != 0);
    endfunction

    function automatic logic expMemWe();
        return rst && (mOwner == 2) && mWe;
    endfunction

    // At every arbitration point the port goes to whichever side is
    // requesting other than the one just finishing, data first.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mOwner   <= 0;
            mElapsed <= 0;
            mAddr    <= '0;
            mWdata   <= '0;
            mWe      <= 1'b0;
            mConf    <= 0;
        end else begin
            if (expStallF() && expStallM() && (mConf < 2**CW - 1)) begin
                mConf <= mConf + 1;
            end
            if ((mOwner != 0) && (mElapsed < LAT - 1)) begin
                mElapsed <= mElapsed + 1;
            end else if (d_req && (mOwner != 2)) begin
                mOwner   <= 2;
                mElapsed <= 0;
                mAddr    <= d_addr;
                mWdata   <= d_wdata;
                mWe      <= d_we;
            end else if (i_req && (mOwner != 1)) begin
                mOwner   <= 1;
                mElapsed <= 0;
                mAddr    <= i_addr;
                mWe      <= 1'b0;
            end else begin
                mOwner <= 0;
            end
        end
    end

    // Per-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        checkOutput("mem_en", mem_en, expMemEn());
        checkOutput("mem_we", mem_we, expMemWe());
        checkOutput("i_ready", i_ready, expIReady());
        checkOutput("d_ready", d_ready, expDReady());
        checkOutput("i_rdata", i_rdata, expIReady() ? mem_rdata : 32'h0);
        checkOutput("d_rdata", d_rdata, (expDReady() && !mWe) ? mem_rdata : 32'h0);
        checkOutput("stall_f", stall_f, expStallF());
        checkOutput("stall_m", stall_m, expStallM());
        checkOutput("conflict_cnt", conflict_cnt, mConf);
        if (expMemEn() || !rst) begin
            checkOutput("mem_addr", mem_addr, mAddr);
        end
        if (expMemWe() || !rst) begin
            checkOutput("mem_wdata", mem_wdata, mWdata);
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                                 input logic dReq, input logic dWe,
                                 input logic [31:0] dAddr, input logic [31:0] dWdata,
                                 input logic [31:0] rdata);
        i_req     = iReq;
        i_addr    = iAddr;
        d_req     = dReq;
        d_we      = dWe;
        d_addr    = dAddr;
        d_wdata   = dWdata;
        mem_rdata = rdata;
    endtask

    initial begin
        int   weCnt;
        int   rdyCnt;
        logic gotRdy;

        rst  = 1'b0;
        rstB = 1'b0;
        applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 32'h100, 32'h0, 32'h1111_2222);

        // Reset held with both requests up, then both sides contend.
        repeat (3) @(posedge clk);
        sample();
        checkOutput("rst_mem_en", mem_en, 1'b0);
        checkOutput("rst_stall_f", stall_f, 1'b0);
        checkOutput("rst_stall_m", stall_m, 1'b0);
        nextCycle();
        rst = 1'b1;
        sample();
        checkOutput("sim_c0_mem_en", mem_en, 1'b0);
        checkOutput("sim_c0_stall_m", stall_m, 1'b1);
        sample();
        checkOutput("sim_c1_mem_en", mem_en, 1'b1);
        checkOutput("sim_c1_mem_addr", mem_addr, 32'h100);
        sample();
        checkOutput("sim_c2_d_ready", d_ready, 1'b1);
        checkOutput("sim_c2_d_rdata", d_rdata, 32'h1111_2222);
        checkOutput("sim_c2_conflict", conflict_cnt, 2);
        nextCycle();
        d_req = 1'b0;
        sample();
        checkOutput("sim_c3_mem_en", mem_en, 1'b1);
        checkOutput("sim_c3_mem_addr", mem_addr, 32'h20);
        sample();
        checkOutput("sim_c4_i_ready", i_ready, 1'b1);
        checkOutput("sim_c4_i_rdata", i_rdata, 32'h1111_2222);
        nextCycle();
        i_req = 1'b0;
        nextCycle();

        // Single fetch from idle.
        nextCycle();
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF);
        sample();
        checkOutput("f_c0_mem_en", mem_en, 1'b0);
        checkOutput("f_c0_stall_f", stall_f, 1'b1);
        sample();
        checkOutput("f_c1_mem_addr", mem_addr, 32'h10);
        checkOutput("f_c1_stall_f", stall_f, 1'b1);
        sample();
        checkOutput("f_c2_i_ready", i_ready, 1'b1);
        checkOutput("f_c2_i_rdata", i_rdata, 32'hDEAD_BEEF);
        checkOutput("f_c2_stall_f", stall_f, 1'b0);
        nextCycle();
        i_req = 1'b0;
        sample();
        checkOutput("f_c3_mem_en", mem_en, 1'b0);

        // Fetch in progress when a load arrives: handed over with no bubble.
        nextCycle();
        applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0BAD_F00D);
        nextCycle();
        d_req  = 1'b1;
        d_addr = 32'h200;
        sample();
        checkOutput("id_c1_mem_addr", mem_addr, 32'h30);
        sample();
        checkOutput("id_c2_i_ready", i_ready, 1'b1);
        nextCycle();
        i_req = 1'b0;
        sample();
        checkOutput("id_c3_mem_addr", mem_addr, 32'h200);
        checkOutput("id_c3_conflict", conflict_cnt, 3);
        sample();
        checkOutput("id_c4_d_rdata", d_rdata, 32'h0BAD_F00D);
        nextCycle();
        d_req = 1'b0;

        // Store: write strobe for exactly LAT cycles, one ready, no load data.
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h1234, 32'hCAFE_F00D);
        weCnt  = 0;
        rdyCnt = 0;
        for (int c = 0; c < 5; c++) begin
            sample();
            gotRdy = d_ready;
            if (mem_we) begin
                weCnt++;
                checkOutput("st_mem_wdata", mem_wdata, 32'h1234);
            end
            if (d_ready) begin
                rdyCnt++;
                checkOutput("st_d_rdata", d_rdata, 32'h0);
            end
            nextCycle();
            if (gotRdy) begin
                d_req = 1'b0;
            end
        end
        checkOutput("st_we_cycles", weCnt, LAT);
        checkOutput("st_ready_pulses", rdyCnt, 1);

        // Reset in the first write cycle aborts the access; it restarts later.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h55, 32'h0);
        nextCycle();
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rm_async_mem_en", mem_en, 1'b0);
        checkOutput("rm_async_mem_we", mem_we, 1'b0);
        sample();
        nextCycle();
        sample();
        checkOutput("rm_no_ready", d_ready, 1'b0);
        nextCycle();
        rst = 1'b1;
        sample();
        checkOutput("rm_r0_mem_en", mem_en, 1'b0);
        checkOutput("rm_r0_d_ready", d_ready, 1'b0);
        sample();
        checkOutput("rm_r1_mem_we", mem_we, 1'b1);
        checkOutput("rm_r1_mem_addr", mem_addr, 32'h80);
        sample();
        checkOutput("rm_r2_d_ready", d_ready, 1'b1);
        nextCycle();
        d_req = 1'b0;

        // Saturation on the small-counter instance with both sides always up.
        nextCycle();
        rstB = 1'b1;
        for (int c = 0; c <= 40; c++) begin
            sample();
            if (c == 10) checkOutput("sat_c10_conflict", conflictB, 10);
            if (c == 15) checkOutput("sat_c15_d_ready", dReadyB, 1'b1);
            if (c == 40) checkOutput("sat_c40_conflict", conflictB, 15);
            nextCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
